// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C-style target decoding 3-phase writes and 2-phase write + 2-phase read transactions
// Ports: clk, rst_n (async, active low), clk_en (global advance enable),
//        SIOC_in/SIOD_in (resolved bus levels), SIOD_oe (1 = pull SIOD low), busy,
//        wr_valid/wr_addr/wr_data (register write strobe), rd_addr (sub-address pointer),
//        rd_data (register-file data for rd_addr).
module sccb_target #(
  parameter logic [7:0] DEV_ADDR = 8'h42,
  parameter logic       ACK_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       SIOC_in,
  input  logic       SIOD_in,
  output logic       SIOD_oe,
  output logic       busy,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data
);
  typedef enum logic [3:0] {
    IDLE, ID_BYTE, ID_ACK, ADDR_BYTE, ADDR_ACK, DATA_BYTE, DATA_ACK, RD_BYTE, RD_NA, WAIT_STOP
  } state_t;
  state_t state, state_nxt;
  logic [2:0] scl_q, sda_q;
  logic [6:0] sr;
  logic [3:0] cnt;
  logic       ack_hi, rw;
  logic       scl_rise, scl_fall, start, stop, in_byte, in_ack, last_bit, ack_end;
  logic [7:0] byte_in;
  // [0],[1] form the synchronizer, [2] holds the previous synchronized sample.
  // Reset to the idle-high bus level so release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else if (clk_en) begin
      scl_q <= {scl_q[1:0], SIOC_in};
      sda_q <= {sda_q[1:0], SIOD_in};
    end
  // An SIOC edge excludes START/STOP because both require SIOC high in both samples.
  always_comb begin
    scl_rise = clk_en & scl_q[1] & ~scl_q[2];
    scl_fall = clk_en & ~scl_q[1] & scl_q[2];
    start    = clk_en & scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
    stop     = clk_en & scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    byte_in  = {sr, sda_q[1]};
    in_byte  = state == ID_BYTE || state == ADDR_BYTE || state == DATA_BYTE;
    in_ack   = state == ID_ACK || state == ADDR_ACK || state == DATA_ACK;
    last_bit = scl_rise & in_byte & (cnt == 4'd7);
    ack_end  = scl_fall & in_ack & ack_hi;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else if (clk_en) state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (start) state_nxt = ID_BYTE;
    else if (stop) state_nxt = IDLE;
    else
      case (state)
        ID_BYTE:   if (last_bit) state_nxt = byte_in[7:1] == DEV_ADDR[7:1] ? ID_ACK : WAIT_STOP;
        ID_ACK:    if (ack_end) state_nxt = rw ? RD_BYTE : ADDR_BYTE;
        ADDR_BYTE: if (last_bit) state_nxt = ADDR_ACK;
        ADDR_ACK:  if (ack_end) state_nxt = DATA_BYTE;
        DATA_BYTE: if (last_bit) state_nxt = DATA_ACK;
        DATA_ACK:  if (ack_end) state_nxt = WAIT_STOP;
        RD_BYTE:   if (scl_fall && cnt == 4'd7) state_nxt = RD_NA;
        RD_NA:     if (scl_rise) state_nxt = WAIT_STOP;
        default:   state_nxt = state;
      endcase
  end
  always_comb busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr       <= '0;
      cnt      <= '0;
      ack_hi   <= 1'b0;
      rw       <= 1'b0;
      SIOD_oe  <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_addr  <= '0;
    end else if (clk_en) begin
      wr_valid <= 1'b0;
      if (start) begin
        cnt     <= '0;
        ack_hi  <= 1'b0;
        SIOD_oe <= 1'b0;
      end else if (stop) begin
        ack_hi  <= 1'b0;
        SIOD_oe <= 1'b0;
      end else begin
        if (scl_rise && in_byte) begin
          sr  <= byte_in[6:0];
          cnt <= last_bit ? 4'd0 : cnt + 4'd1;
        end
        if (last_bit && state == ID_BYTE) rw <= byte_in[0];
        if (last_bit && state == ADDR_BYTE) rd_addr <= byte_in;
        if (last_bit && state == DATA_BYTE) begin
          wr_addr  <= rd_addr;
          wr_data  <= byte_in;
          wr_valid <= 1'b1;
        end
        // First fall after an accepted byte drives the ack, the second releases it.
        if (scl_fall && in_ack) begin
          ack_hi  <= ~ack_hi;
          SIOD_oe <= ~ack_hi & ACK_EN;
        end
        // The ack release edge of a read ID also puts the first read bit on the bus.
        if (ack_end && state == ID_ACK && rw) begin
          sr      <= rd_data[6:0];
          SIOD_oe <= ~rd_data[7];
          cnt     <= '0;
        end
        // cnt counts bits already presented; the 8th fall ends the last bit and releases.
        if (scl_fall && state == RD_BYTE) begin
          sr      <= {sr[5:0], 1'b0};
          SIOD_oe <= (cnt != 4'd7) & ~sr[6];
          cnt     <= cnt + 4'd1;
        end
      end
    end
endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed + randomized bench for sccb_target against a transaction-level model
module tb_sccb_target;
  localparam int Q = 10;
  logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, tog = 1'b0;
  logic scl_m = 1'b1, sda_m = 1'b1;
  logic oe0, oe1, busy0, busy1, wv0, wv1;
  logic [7:0] wa0, wd0, ra0, wa1, wd1, ra1;
  logic [7:0] mem [256];
  logic sda_bus;
  int checks = 0, errors = 0, wcnt0 = 0, wcnt1 = 0;
  logic [7:0] m_ptr = 8'h00, m_wa = 8'h00, m_wd = 8'h00;
  int m_w = 0;
  logic p0 = 1'b0, p1 = 1'b0, pr = 1'b0;
  assign sda_bus = sda_m & ~oe0;
  sccb_target #(.DEV_ADDR(8'h42), .ACK_EN(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .SIOC_in(scl_m), .SIOD_in(sda_bus),
    .SIOD_oe(oe0), .busy(busy0), .wr_valid(wv0), .wr_addr(wa0), .wr_data(wd0),
    .rd_addr(ra0), .rd_data(mem[ra0])
  );
  sccb_target #(.DEV_ADDR(8'h42), .ACK_EN(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .SIOC_in(scl_m), .SIOD_in(sda_bus),
    .SIOD_oe(oe1), .busy(busy1), .wr_valid(wv1), .wr_addr(wa1), .wr_data(wd1),
    .rd_addr(ra1), .rd_data(mem[ra1])
  );
  always #5 clk = ~clk;
  always @(negedge clk) clk_en = tog ? ~clk_en : 1'b1;
  always @(posedge clk) begin
    if (wv0 && clk_en) wcnt0++;
    if (wv1 && clk_en) wcnt1++;
  end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // SIOD_oe may only move while the master holds SIOC low.
  always @(negedge clk) begin
    if (rst_n && pr && scl_m) begin
      chk("oe0_hold_scl_high", 16'(oe0), 16'(p0));
      chk("oe1_hold_scl_high", 16'(oe1), 16'(p1));
    end
    p0 = oe0;
    p1 = oe1;
    pr = rst_n;
  end
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic bus_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    sda_m = 1'b0; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask
  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    sda_m = 1'b1; wait_clk(2 * Q);
  endtask
  task automatic send_bit(input logic b, output logic o0, output logic o1);
    sda_m = b; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    o0 = oe0; o1 = oe1; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask
  // Nine bits MSB first, master releasing on the 9th; o[8] is the first bit, o[0] the 9th.
  task automatic send_byte(input logic [7:0] v, output logic [8:0] o0, output logic [8:0] o1);
    logic [8:0] s;
    logic a, b;
    s = {v, 1'b1};
    for (int i = 8; i >= 0; i--) begin
      send_bit(s[i], a, b);
      o0[i] = a;
      o1[i] = b;
    end
  endtask
  task automatic check_regs(input string tag);
    chk({tag, "_wcnt0"}, 16'(wcnt0), 16'(m_w));
    chk({tag, "_wcnt1"}, 16'(wcnt1), 16'(m_w));
    chk({tag, "_wr_addr"}, 16'(wa0), 16'(m_wa));
    chk({tag, "_wr_data"}, 16'(wd0), 16'(m_wd));
    chk({tag, "_rd_addr"}, 16'(ra0), 16'(m_ptr));
    chk({tag, "_noack_wr_data"}, 16'(wd1), 16'(m_wd));
  endtask
  task automatic write_body(input string tag, input logic [7:0] id, input logic [7:0] a, input logic [7:0] d);
    logic [8:0] o0, o1, ack;
    logic hit;
    hit = id[7:1] == 7'h21;
    ack = hit ? 9'h001 : 9'h000;
    send_byte(id, o0, o1);
    chk({tag, "_id_ack"}, 16'(o0), 16'(ack));
    chk({tag, "_id_noack"}, 16'(o1), 16'h0);
    send_byte(a, o0, o1);
    chk({tag, "_addr_ack"}, 16'(o0), 16'(ack));
    chk({tag, "_addr_noack"}, 16'(o1), 16'h0);
    send_byte(d, o0, o1);
    chk({tag, "_data_ack"}, 16'(o0), 16'(ack));
    chk({tag, "_data_noack"}, 16'(o1), 16'h0);
    chk({tag, "_busy_before_stop"}, 16'(busy0), 16'h1);
    bus_stop();
    chk({tag, "_busy_after_stop"}, 16'(busy0), 16'h0);
    if (hit) begin
      m_ptr = a;
      m_wa = a;
      m_wd = d;
      m_w++;
    end
    check_regs(tag);
  endtask
  task automatic write3(input string tag, input logic [7:0] id, input logic [7:0] a, input logic [7:0] d);
    bus_start();
    chk({tag, "_busy_start"}, 16'(busy0), 16'h1);
    write_body(tag, id, a, d);
  endtask
  task automatic write2(input string tag, input logic [7:0] a);
    logic [8:0] o0, o1;
    bus_start();
    send_byte(8'h42, o0, o1);
    chk({tag, "_id_ack"}, 16'(o0), 16'h001);
    send_byte(a, o0, o1);
    chk({tag, "_addr_ack"}, 16'(o0), 16'h001);
    bus_stop();
    m_ptr = a;
    check_regs(tag);
  endtask
  task automatic read1(input string tag);
    logic [8:0] o0, o1;
    logic [7:0] v;
    bus_start();
    send_byte(8'h43, o0, o1);
    chk({tag, "_id_ack"}, 16'(o0), 16'h001);
    v = ~mem[m_ptr];
    send_byte(8'hFF, o0, o1);
    chk({tag, "_rd_bits"}, 16'(o0), 16'({v, 1'b0}));
    bus_stop();
    chk({tag, "_busy_after_stop"}, 16'(busy0), 16'h0);
    check_regs(tag);
  endtask
  initial begin
    logic [8:0] o0, o1;
    logic a, b;
    logic [7:0] ra, rd, id;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    wait_clk(5);
    chk("rst_oe", 16'(oe0), 16'h0);
    chk("rst_busy", 16'(busy0), 16'h0);
    chk("rst_wr_valid", 16'(wv0), 16'h0);
    chk("rst_wr_addr", 16'(wa0), 16'h0);
    chk("rst_wr_data", 16'(wd0), 16'h0);
    chk("rst_rd_addr", 16'(ra0), 16'h0);
    rst_n = 1'b1;
    wait_clk(5);
    write3("full_write", 8'h42, 8'h12, 8'h80);
    write3("id_mismatch", 8'h60, 8'($urandom), 8'($urandom));
    write3("after_mismatch", 8'h42, 8'h3A, 8'h04);
    mem[8'h0A] = 8'h76;
    write2("two_phase", 8'h0A);
    read1("read_76");
    // Repeated START four bits into the data byte aborts the write.
    ra = 8'($urandom);
    rd = 8'($urandom);
    bus_start();
    send_byte(8'h42, o0, o1);
    chk("rs_id_ack", 16'(o0), 16'h001);
    send_byte(ra, o0, o1);
    chk("rs_addr_ack", 16'(o0), 16'h001);
    m_ptr = ra;
    for (int i = 7; i >= 4; i--) send_bit(rd[i], a, b);
    bus_start();
    chk("rs_busy", 16'(busy0), 16'h1);
    chk("rs_no_write", 16'(wcnt0), 16'(m_w));
    chk("rs_rd_addr", 16'(ra0), 16'(ra));
    write_body("rs_rewrite", 8'h42, 8'h11, 8'($urandom));
    // Reset while the ID ack is being driven.
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'h42 >> i) & 8'h1) != 8'h0, a, b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    chk("rst_mid_pre_oe", 16'(oe0), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_oe", 16'(oe0), 16'h0);
    chk("rst_mid_busy", 16'(busy0), 16'h0);
    chk("rst_mid_wr_valid", 16'(wv0), 16'h0);
    chk("rst_mid_wr_addr", 16'(wa0), 16'h0);
    chk("rst_mid_wr_data", 16'(wd0), 16'h0);
    chk("rst_mid_rd_addr", 16'(ra0), 16'h0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), a, b);
    bus_stop();
    m_ptr = 8'h00;
    m_wa = 8'h00;
    m_wd = 8'h00;
    check_regs("rst_mid_after");
    write3("post_reset", 8'h42, 8'($urandom), 8'($urandom));
    tog = 1'b1;
    write3("half_rate", 8'h42, 8'($urandom), 8'($urandom));
    tog = 1'b0;
    wait_clk(4);
    for (int n = 0; n < 8; n++) begin
      case ($urandom_range(0, 2))
        0: begin
          id = {7'($urandom_range(0, 127)), 1'b0};
          if ($urandom_range(0, 3) != 0) id = 8'h42;
          write3("rand_write", id, 8'($urandom), 8'($urandom));
        end
        1: write2("rand_write2", 8'($urandom));
        default: read1("rand_read");
      endcase
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
